mem_port_arbiter: RTL

- Two-requester arbiter/sequencer in front of the unified memory's data port (ren/wen/data_addr/data_in/byte_select_vector/data_out/ready).
- Port 0 is the scalar LSU; port 1 is the vector load/store unit.
- Serialises accesses, issues single-cycle strobes to memory, waits on the multi-cycle read `ready`, and returns data plus a done pulse to the granted requester.
- Adds round-robin fairness, out-of-range rejection and a read timeout.

---
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer between the scalar LSU (port 0) and the vector LSU (port 1)
// in front of the unified memory data port, with out-of-range rejection and a read timeout.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W    = 30,
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned TIMEOUT   = 31,
  localparam int unsigned DATA_W   = 32,
  localparam int unsigned BSEL_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_wen,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [BSEL_W-1:0] p0_bsel,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_done,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_wen,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic [BSEL_W-1:0] p1_bsel,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_done,
  output logic              p1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BSEL_W-1:0] mem_bsel,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic              id;
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BSEL_W-1:0] bsel;
  } req_t;

  state_t           state;
  req_t             req_q;
  logic [CNT_W-1:0] cnt;
  logic             last_grant;

  logic             any_req_c;
  logic             oor_c;
  req_t             win_c;
  logic             cmpl_c;
  logic             cmpl_id_c;
  logic             cmpl_err_c;
  logic             cmpl_upd_c;
  logic [DATA_W-1:0] cmpl_data_c;

  // Round-robin pick: on a tie the port that did not win last time goes next.
  always_comb begin
    any_req_c = p0_req | p1_req;
    win_c.id  = (p0_req & p1_req) ? ~last_grant : p1_req;
    if (win_c.id) begin
      win_c.wen   = p1_wen;
      win_c.addr  = p1_addr;
      win_c.wdata = p1_wdata;
      win_c.bsel  = p1_bsel;
    end else begin
      win_c.wen   = p0_wen;
      win_c.addr  = p0_addr;
      win_c.wdata = p0_wdata;
      win_c.bsel  = p0_bsel;
    end
    oor_c = {1'b0, win_c.addr} >= (ADDR_W + 1)'(MEM_WORDS);
  end

  // Completion event for the cycle that moves the FSM into RESP.
  always_comb begin
    cmpl_c      = 1'b0;
    cmpl_id_c   = req_q.id;
    cmpl_err_c  = 1'b0;
    cmpl_upd_c  = 1'b0;
    cmpl_data_c = '0;
    case (state)
      IDLE: begin
        if (any_req_c && oor_c) begin
          cmpl_c     = 1'b1;
          cmpl_id_c  = win_c.id;
          cmpl_err_c = 1'b1;
          cmpl_upd_c = 1'b1;
        end
      end
      ISSUE: cmpl_c = req_q.wen;
      WAIT: begin
        // mem_ready in the first WAIT cycle may still be left over from a previous read.
        if ((cnt != '0) && mem_ready) begin
          cmpl_c      = 1'b1;
          cmpl_upd_c  = 1'b1;
          cmpl_data_c = mem_rdata;
        end else if (cnt == CNT_W'(TIMEOUT)) begin
          cmpl_c     = 1'b1;
          cmpl_err_c = 1'b1;
          cmpl_upd_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req_q      <= '0;
      cnt        <= '0;
      last_grant <= 1'b1;
      mem_ren    <= 1'b0;
      mem_wen    <= 1'b0;
    end else begin
      mem_ren <= 1'b0;
      mem_wen <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req_c) begin
            req_q <= win_c;
            if (oor_c) begin
              state <= RESP;
            end else begin
              state   <= ISSUE;
              mem_ren <= ~win_c.wen;
              mem_wen <= win_c.wen;
            end
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= req_q.wen ? RESP : WAIT;
        end
        WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (cmpl_c) state <= RESP;
        end
        RESP: begin
          last_grant <= req_q.id;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-port response registers; rdata/err hold until that port's next completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p0_done  <= 1'b0;
      p0_err   <= 1'b0;
      p0_rdata <= '0;
      p1_done  <= 1'b0;
      p1_err   <= 1'b0;
      p1_rdata <= '0;
    end else begin
      p0_done <= cmpl_c & ~cmpl_id_c;
      p1_done <= cmpl_c & cmpl_id_c;
      if (cmpl_c && !cmpl_id_c) begin
        p0_err <= cmpl_err_c;
        if (cmpl_upd_c) p0_rdata <= cmpl_data_c;
      end
      if (cmpl_c && cmpl_id_c) begin
        p1_err <= cmpl_err_c;
        if (cmpl_upd_c) p1_rdata <= cmpl_data_c;
      end
    end
  end

  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign mem_bsel  = req_q.bsel;
  assign busy      = (state != IDLE);

endmodule
